// File: rtl/buf_mem_responder_if.sv
// Bus bundle between the matrix multiply core / host side and one buffer
// memory responder. Signal names carry the responder's point of view:
// *_i are driven by the master, *_o are driven by the responder.
//
// Parameters:
//   DW - word width in bits (LANES * WIDTH of the responder)
//   AW - address width
//
// Signals:
//   core_cenb_i, core_wenb_i   active-low core enable / write enable
//   core_addr_i, core_data_i   core address and write data
//   core_data_o                core read data (1-cycle latency)
//   host_req_i, host_we_i      host request and write(1)/read(0)
//   host_addr_i, host_wdata_i  host address and write data
//   host_gnt_o                 host access accepted this cycle
//   host_rvalid_o, host_rdata_o host read response
interface buf_mem_responder_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  logic          core_cenb_i;
  logic          core_wenb_i;
  logic [AW-1:0] core_addr_i;
  logic [DW-1:0] core_data_i;
  logic [DW-1:0] core_data_o;
  logic          host_req_i;
  logic          host_we_i;
  logic [AW-1:0] host_addr_i;
  logic [DW-1:0] host_wdata_i;
  logic          host_gnt_o;
  logic          host_rvalid_o;
  logic [DW-1:0] host_rdata_o;

  modport master (
    output core_cenb_i, core_wenb_i, core_addr_i, core_data_i,
    output host_req_i, host_we_i, host_addr_i, host_wdata_i,
    input  core_data_o, host_gnt_o, host_rvalid_o, host_rdata_o
  );

  modport slave (
    input  core_cenb_i, core_wenb_i, core_addr_i, core_data_i,
    input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
    output core_data_o, host_gnt_o, host_rvalid_o, host_rdata_o
  );
endinterface

// File: rtl/buf_mem_responder.sv
// Memory-side responder for one matrix multiply buffer (input, weight,
// partial-sum or output). Holds DEPTH words of LANES x WIDTH bits and serves
// the core with a fixed 1-cycle read latency. A lower-priority host port
// (req/gnt) is used to preload operands and drain results; the core always
// wins, so the memory is effectively single ported.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset (memory contents are kept)
//   clr_i        synchronous clear of the sticky flags and the stall counter
//   bus          core and host access signals (buf_mem_responder_if.slave)
//   oob_err_o    sticky: an access used an address >= DEPTH
//   stall_cnt_o  saturating count of cycles the host waited for a grant
//
// Optional feature, macro BUF_PARITY_EN:
//   each word keeps an even-parity bit; reads that see a mismatch set the
//   sticky parity_err_o. host_par_flip_i inverts the stored bit on a granted
//   host write so the checker can be exercised.
module buf_mem_responder #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = LANES * WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  buf_mem_responder_if.slave        bus,
  output logic                      oob_err_o,
  output logic [15:0]               stall_cnt_o
`ifdef BUF_PARITY_EN
  ,
  input  logic                      host_par_flip_i,
  output logic                      parity_err_o
`endif
);

  logic [DW-1:0] mem_array [DEPTH];

  logic          host_gnt;
  logic          core_act;
  logic          acc_en;
  logic          acc_write;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          acc_in_range;
  logic [DW-1:0] rd_word;
  logic          mem_we;

  logic [DW-1:0] core_data_d, core_data_q;
  logic [DW-1:0] host_rdata_d, host_rdata_q;
  logic          host_rvalid_d, host_rvalid_q;
  logic          oob_err_d, oob_err_q;
  logic [15:0]   stall_cnt_d, stall_cnt_q;

  // Core and host never access in the same cycle, so a single shared access
  // path is selected here; out-of-range addresses read as zero and never write.
  always_comb begin
    host_gnt     = bus.host_req_i & bus.core_cenb_i;
    core_act     = ~bus.core_cenb_i;
    acc_en       = core_act | host_gnt;
    acc_write    = core_act ? ~bus.core_wenb_i : (host_gnt & bus.host_we_i);
    acc_addr     = core_act ? bus.core_addr_i : bus.host_addr_i;
    acc_wdata    = core_act ? bus.core_data_i : bus.host_wdata_i;
    acc_in_range = int'(acc_addr) < DEPTH;
    rd_word      = acc_in_range ? mem_array[acc_addr] : '0;
    mem_we       = acc_en & acc_write & acc_in_range;
  end

  // Response registers and sticky status. A clear and a new event in the same
  // cycle resolve in favour of the event, so the event is applied after the
  // clear.
  always_comb begin
    core_data_d = core_data_q;
    if (core_act & bus.core_wenb_i) core_data_d = rd_word;

    host_rvalid_d = host_gnt & ~bus.host_we_i;
    host_rdata_d  = host_rvalid_d ? rd_word : host_rdata_q;

    oob_err_d = clr_i ? 1'b0 : oob_err_q;
    if (acc_en & ~acc_in_range) oob_err_d = 1'b1;

    stall_cnt_d = clr_i ? 16'd0 : stall_cnt_q;
    if (bus.host_req_i & ~host_gnt & (stall_cnt_d != 16'hFFFF))
      stall_cnt_d = stall_cnt_d + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_data_q   <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      oob_err_q     <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      core_data_q   <= core_data_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      oob_err_q     <= oob_err_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // Storage is deliberately not reset so preloaded operands survive a reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_array[acc_addr] <= acc_wdata;
  end

`ifdef BUF_PARITY_EN
  logic par_array [DEPTH];
  logic wr_par;
  logic parity_err_d, parity_err_q;

  // Even parity: the stored bit equals the XOR of the data, so a healthy word
  // recomputes to the same value. The flip only applies to granted host writes.
  always_comb begin
    wr_par       = (^acc_wdata) ^ (host_gnt & host_par_flip_i);
    parity_err_d = clr_i ? 1'b0 : parity_err_q;
    if (acc_en & ~acc_write & acc_in_range &
        ((^rd_word) != par_array[acc_addr]))
      parity_err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) parity_err_q <= 1'b0;
    else       parity_err_q <= parity_err_d;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) par_array[acc_addr] <= wr_par;
  end

  assign parity_err_o = parity_err_q;
`endif

  assign bus.host_gnt_o    = host_gnt;
  assign bus.core_data_o   = core_data_q;
  assign bus.host_rvalid_o = host_rvalid_q;
  assign bus.host_rdata_o  = host_rdata_q;
  assign oob_err_o         = oob_err_q;
  assign stall_cnt_o       = stall_cnt_q;

endmodule

// File: tb/tb_buf_mem_responder.sv
// Self-checking bench for buf_mem_responder (DEPTH = 200 so out-of-range
// addresses exist). Directed table vectors with hand-derived expectations,
// hand-written multi-cycle sequences (stall saturation, reset during a read,
// parity injection when BUF_PARITY_EN is defined), then randomized traffic
// checked against an array-based reference model.
module tb_buf_mem_responder;
  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int DEPTH = 200;
  localparam int AW    = 8;
  localparam int DW    = 32;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct {
    logic          cenb;
    logic          wenb;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cdata;
    logic          req;
    logic          we;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwdata;
    logic          clr;
    logic          gnt;
    logic [DW-1:0] core_data;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          oob;
    logic [15:0]   stall;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clr_i;
  logic        oob_err_o;
  logic [15:0] stall_cnt_o;
`ifdef BUF_PARITY_EN
  logic        host_par_flip_i;
  logic        parity_err_o;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_core;
  logic [DW-1:0] m_rdata;
  logic          m_rvalid;
  logic          m_oob;
  logic [15:0]   m_stall;

  vec_t vecs[$];

  buf_mem_responder_if #(.DW(DW), .AW(AW)) bus();

  buf_mem_responder #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(clr_i),
    .bus(bus),
    .oob_err_o(oob_err_o),
    .stall_cnt_o(stall_cnt_o)
`ifdef BUF_PARITY_EN
    ,
    .host_par_flip_i(host_par_flip_i),
    .parity_err_o(parity_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk_vec(
    input logic cenb, input logic wenb, input logic [AW-1:0] caddr,
    input logic [DW-1:0] cdata, input logic req, input logic we,
    input logic [AW-1:0] haddr, input logic [DW-1:0] hwdata, input logic clr,
    input logic gnt, input logic [DW-1:0] core_data, input logic rvalid,
    input logic [DW-1:0] rdata, input logic oob, input logic [15:0] stall);
    vec_t v;
    v.cenb = cenb;   v.wenb = wenb;     v.caddr = caddr;       v.cdata = cdata;
    v.req = req;     v.we = we;         v.haddr = haddr;       v.hwdata = hwdata;
    v.clr = clr;     v.gnt = gnt;       v.core_data = core_data;
    v.rvalid = rvalid; v.rdata = rdata; v.oob = oob;           v.stall = stall;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.core_cenb_i  = v.cenb;
    bus.core_wenb_i  = v.wenb;
    bus.core_addr_i  = v.caddr;
    bus.core_data_i  = v.cdata;
    bus.host_req_i   = v.req;
    bus.host_we_i    = v.we;
    bus.host_addr_i  = v.haddr;
    bus.host_wdata_i = v.hwdata;
    clr_i            = v.clr;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t idle_vec();
    return mk_vec(H, H, 8'd0, 32'd0, L, L, 8'd0, 32'd0, L,
                  L, 32'd0, L, 32'd0, L, 16'd0);
  endfunction

  task automatic check_all(input string tag, input logic [DW-1:0] cd,
                           input logic rv, input logic [DW-1:0] rd,
                           input logic oob, input logic [15:0] st);
    check_output({tag, " core_data"}, bus.core_data_o, cd);
    check_output({tag, " rvalid"}, 32'(bus.host_rvalid_o), 32'(rv));
    check_output({tag, " rdata"}, bus.host_rdata_o, rd);
    check_output({tag, " oob"}, 32'(oob_err_o), 32'(oob));
    check_output({tag, " stall"}, 32'(stall_cnt_o), 32'(st));
  endtask

  // Drive one table vector, check the combinational grant, then the
  // registered outputs after the edge.
  task automatic apply_stimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive(v);
    #1;
    check_output({tag, " gnt"}, 32'(bus.host_gnt_o), 32'(v.gnt));
    tick();
    check_all(tag, v.core_data, v.rvalid, v.rdata, v.oob, v.stall);
  endtask

  // One cycle of model-checked traffic: the model applies the access rules
  // directly to its array and expected registers.
  task automatic model_step(input vec_t v, output logic granted);
    logic exp_gnt;
    exp_gnt = v.req && v.cenb;
    drive(v);
    #1;
    check_output("rand gnt", 32'(bus.host_gnt_o), 32'(exp_gnt));
    if (v.clr) begin
      m_oob   = 1'b0;
      m_stall = 16'd0;
    end
    if (v.req && !exp_gnt && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    m_rvalid = 1'b0;
    if (!v.cenb) begin
      if (int'(v.caddr) >= DEPTH) m_oob = 1'b1;
      else if (!v.wenb) m_mem[v.caddr] = v.cdata;
      if (v.wenb) m_core = (int'(v.caddr) < DEPTH) ? m_mem[v.caddr] : 32'd0;
    end else if (exp_gnt) begin
      if (int'(v.haddr) >= DEPTH) m_oob = 1'b1;
      else if (v.we) m_mem[v.haddr] = v.hwdata;
      if (!v.we) begin
        m_rvalid = 1'b1;
        m_rdata  = (int'(v.haddr) < DEPTH) ? m_mem[v.haddr] : 32'd0;
      end
    end
    tick();
    check_all("rand", m_core, m_rvalid, m_rdata, m_oob, m_stall);
`ifdef BUF_PARITY_EN
    check_output("rand parity_err", 32'(parity_err_o), 32'd0);
`endif
    granted = exp_gnt;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(idle_vec());
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    m_core = '0; m_rdata = '0; m_rvalid = 1'b0; m_oob = 1'b0; m_stall = '0;
  endtask

  initial begin
    vec_t v;
    logic pend;
    logic granted;

    rst_i = 1'b1;
`ifdef BUF_PARITY_EN
    host_par_flip_i = 1'b0;
`endif
    drive(idle_vec());
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset", 32'd0, L, 32'd0, L, 16'd0);
    rst_i = 1'b0;

    // cenb wenb caddr cdata | req we haddr hwdata clr || gnt core_data rvalid rdata oob stall
    vecs.push_back(mk_vec(H, H, 8'd0,   32'd0,        H, H, 8'd5,   32'hA1B2C3D4, L, H, 32'd0,        L, 32'd0,        L, 16'd0));
    vecs.push_back(mk_vec(H, H, 8'd0,   32'd0,        H, L, 8'd5,   32'd0,        L, H, 32'd0,        H, 32'hA1B2C3D4, L, 16'd0));
    vecs.push_back(mk_vec(H, H, 8'd0,   32'd0,        L, L, 8'd0,   32'd0,        L, L, 32'd0,        L, 32'hA1B2C3D4, L, 16'd0));
    vecs.push_back(mk_vec(L, L, 8'd10,  32'h01020304, L, L, 8'd0,   32'd0,        L, L, 32'd0,        L, 32'hA1B2C3D4, L, 16'd0));
    vecs.push_back(mk_vec(L, H, 8'd10,  32'd0,        L, L, 8'd0,   32'd0,        L, L, 32'h01020304, L, 32'hA1B2C3D4, L, 16'd0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk_vec(H, H, 8'd0, 32'd0,        L, L, 8'd0,   32'd0,        L, L, 32'h01020304, L, 32'hA1B2C3D4, L, 16'd0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk_vec(L, H, 8'd5, 32'd0,        H, L, 8'd5,   32'd0,        L, L, 32'hA1B2C3D4, L, 32'hA1B2C3D4, L, 16'(i)));
    vecs.push_back(mk_vec(H, H, 8'd0,   32'd0,        H, L, 8'd5,   32'd0,        L, H, 32'hA1B2C3D4, H, 32'hA1B2C3D4, L, 16'd4));
    vecs.push_back(mk_vec(H, H, 8'd0,   32'd0,        L, L, 8'd0,   32'd0,        H, L, 32'hA1B2C3D4, L, 32'hA1B2C3D4, L, 16'd0));
    vecs.push_back(mk_vec(H, H, 8'd0,   32'd0,        H, H, 8'd210, 32'hDEADBEEF, L, H, 32'hA1B2C3D4, L, 32'hA1B2C3D4, H, 16'd0));
    vecs.push_back(mk_vec(L, H, 8'd210, 32'd0,        L, L, 8'd0,   32'd0,        L, L, 32'd0,        L, 32'hA1B2C3D4, H, 16'd0));
    vecs.push_back(mk_vec(H, H, 8'd0,   32'd0,        H, L, 8'd210, 32'd0,        L, H, 32'd0,        H, 32'd0,        H, 16'd0));
    vecs.push_back(mk_vec(H, H, 8'd0,   32'd0,        L, L, 8'd0,   32'd0,        L, L, 32'd0,        L, 32'd0,        H, 16'd0));
    vecs.push_back(mk_vec(L, H, 8'd5,   32'd0,        H, H, 8'd7,   32'h11111111, H, L, 32'hA1B2C3D4, L, 32'd0,        L, 16'd1));
    vecs.push_back(mk_vec(H, H, 8'd0,   32'd0,        H, H, 8'd7,   32'h11111111, H, H, 32'hA1B2C3D4, L, 32'd0,        L, 16'd0));
    vecs.push_back(mk_vec(H, H, 8'd0,   32'd0,        H, L, 8'd250, 32'd0,        H, H, 32'hA1B2C3D4, H, 32'd0,        H, 16'd0));
    vecs.push_back(mk_vec(H, H, 8'd0,   32'd0,        L, L, 8'd0,   32'd0,        H, L, 32'hA1B2C3D4, L, 32'd0,        L, 16'd0));
    vecs.push_back(mk_vec(H, H, 8'd0,   32'd0,        H, L, 8'd10,  32'd0,        L, H, 32'hA1B2C3D4, H, 32'h01020304, L, 16'd0));
    vecs.push_back(mk_vec(H, H, 8'd0,   32'd0,        H, L, 8'd7,   32'd0,        L, H, 32'hA1B2C3D4, H, 32'h11111111, L, 16'd0));

    foreach (vecs[i]) apply_stimulus(i, vecs[i]);

    // Stall counter saturation: core busy while the host waits.
    v = idle_vec();
    v.cenb = L; v.wenb = H; v.caddr = 8'd5; v.req = H; v.we = L; v.haddr = 8'd9;
    drive(v);
    repeat (65533) @(posedge clk_i);
    tick();
    check_output("sat stall_fffe", 32'(stall_cnt_o), 32'h0000FFFE);
    tick();
    check_output("sat stall_ffff", 32'(stall_cnt_o), 32'h0000FFFF);
    tick();
    tick();
    check_output("sat stall_hold", 32'(stall_cnt_o), 32'h0000FFFF);
    v = idle_vec();
    v.clr = H;
    drive(v);
    tick();
    check_output("sat stall_clr", 32'(stall_cnt_o), 32'd0);

    // Reset on the edge right after a granted host read cancels the response.
    v = idle_vec();
    v.req = H; v.we = H; v.haddr = 8'd220; v.hwdata = 32'h12345678;
    drive(v);
    tick();
    check_output("rst pre oob", 32'(oob_err_o), 32'd1);
    v = idle_vec();
    v.req = H; v.we = L; v.haddr = 8'd5;
    drive(v);
    #1;
    check_output("rst gnt", 32'(bus.host_gnt_o), 32'd1);
    @(posedge clk_i);
    rst_i = 1'b1;
    #1;
    check_all("rst during", 32'd0, L, 32'd0, L, 16'd0);
    tick();
    check_output("rst held rvalid", 32'(bus.host_rvalid_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check_output("rst regnt", 32'(bus.host_gnt_o), 32'd1);
    tick();
    check_output("rst after rvalid", 32'(bus.host_rvalid_o), 32'd1);
    check_output("rst after rdata", bus.host_rdata_o, 32'hA1B2C3D4);
    drive(idle_vec());
    tick();
    check_output("rst after pulse", 32'(bus.host_rvalid_o), 32'd0);

`ifdef BUF_PARITY_EN
    v = idle_vec();
    v.req = H; v.we = H; v.haddr = 8'd3; v.hwdata = 32'h5A5A5A5B;
    host_par_flip_i = 1'b1;
    drive(v);
    tick();
    host_par_flip_i = 1'b0;
    check_output("par after flip write", 32'(parity_err_o), 32'd0);
    v.we = L;
    drive(v);
    tick();
    check_output("par flag", 32'(parity_err_o), 32'd1);
    check_output("par data", bus.host_rdata_o, 32'h5A5A5A5B);
    v.we = H; v.haddr = 8'd4; v.hwdata = 32'h0F0F0F0E;
    drive(v);
    tick();
    v.we = L;
    drive(v);
    tick();
    check_output("par clean data", bus.host_rdata_o, 32'h0F0F0F0E);
    check_output("par clean flag", 32'(parity_err_o), 32'd1);
    v = idle_vec();
    v.clr = H;
    drive(v);
    tick();
    check_output("par clr", 32'(parity_err_o), 32'd0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int a = 0; a < DEPTH; a++) begin
      v = idle_vec();
      v.req = H; v.we = H; v.haddr = 8'(a); v.hwdata = $urandom;
      model_step(v, granted);
    end
    pend = 1'b0;
    v = idle_vec();
    for (int n = 0; n < 3000; n++) begin
      if (!pend) begin
        v.req = ($urandom_range(0, 1) == 0);
        v.we = $urandom_range(0, 1) == 1;
        v.haddr = 8'($urandom_range(0, 219));
        v.hwdata = $urandom;
        pend = v.req;
      end
      v.cenb = $urandom_range(0, 1) == 1;
      v.wenb = $urandom_range(0, 1) == 1;
      v.caddr = 8'($urandom_range(0, 219));
      v.cdata = $urandom;
      v.clr = ($urandom_range(0, 19) == 0);
      model_step(v, granted);
      if (granted) begin
        pend = 1'b0;
        v.req = L;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
